pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised elastic pipeline register that carries one packed stage record (fetch, decode, execute, memory or writeback data) between two adjacent pipeline stages. It uses a valid/ready handshake and supports two modes. Mode 0 is a single register with a combinational ready. Mode 1 is a two-entry skid buffer with a registered ready, which cuts the timing path. It also provides a synchronous flush for branch/jump squash, an occupancy output and a saturating back-pressure counter. One instance sits between each pair of stages, replacing the global per-stage enable vector with local flow control.

## Interface
- `WIDTH`, default 32: payload width in bits; set to `$bits` of the stage record.
- `SKID`, default 1: mode select. 0 = single register; 1 = two-entry skid buffer.
- `CNT_W`, default 16: width of the stall counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  squash all buffered beats at the next edge.
- `in_valid`  in  1  upstream offers a beat.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  block presents a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  WIDTH  presented payload.
- `level`  out  2  beats currently held (0..1 in mode 0; 0..2 in mode 1).
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
**Handshake rules**
- An input beat is accepted when `in_valid && in_ready`.
- An output beat is delivered when `out_valid && out_ready`.
- Once `out_valid` is asserted, `out_data` is held stable until delivery or flush.

**Mode 0 (single register)**
- State: `main_v`, `main_d`.
- `in_ready = !main_v || out_ready` (combinational).
- On accept: `main_d <= in_data`, `main_v <= 1`.
- On deliver with no accept: `main_v <= 0`.

**Mode 1 (skid buffer)**
- State: `main_v/main_d` and `skid_v/skid_d`.
- `in_ready = !skid_v`, driven straight from a flop.
- Transitions, evaluated each cycle:
  - EMPTY (`main_v=0`): accept → main. Next state FULL1.
  - FULL1 (`main_v=1, skid_v=0`):
    - deliver and accept → main refilled, stays FULL1.
    - deliver only → EMPTY.
    - accept only → skid loaded, FULL2.
  - FULL2 (`main_v=1, skid_v=1`): `in_ready=0`; deliver → `main_d <= skid_d`, `skid_v <= 0`, FULL1.
- Beat order is strictly preserved. No beat is lost or duplicated.

**Common behaviour**
- `level = main_v + skid_v`.
- Flush:
  - At the next edge `main_v` and `skid_v` clear to 0.
  - A beat accepted in the flush cycle is discarded.
  - A beat delivered in the flush cycle counts as delivered; downstream may consume it.
  - Flush does not clear `stall_cnt`.
- Simultaneous `reset` and `flush`: reset wins; the result is identical.
- Stall counter:
  - Increments by 1 on each cycle with `out_valid && !out_ready`.
  - Holds at `2^CNT_W-1`; no wrap.
  - Cleared only by reset.
- `out_data` is not cleared on flush. It is don't-care while `out_valid=0`.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `level=0`, `stall_cnt=0`.
  - Mode 1: `in_ready=1` from the first cycle after reset.
  - Mode 0: `in_ready=1` combinationally.
- While `reset=1`, input beats are ignored and nothing is delivered.
- Latency: an accept at edge N gives `out_valid=1` in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained in both modes when `out_ready=1`.
- Mode 1 ready path: `in_ready` deasserts in the cycle after the skid entry fills. No combinational path from `out_ready` to `in_ready`.
- Mode 0 ready path: a combinational path from `out_ready` to `in_ready` is allowed.
- Mode 1 recovery: with `out_ready` held 0, the 3rd offered beat is refused. After `out_ready` rises, the refused beat is accepted on the 2nd edge.

## Test plan
1. **Stream, mode 1.** `out_ready=1`; offer 0x11, 0x22, 0x33 on consecutive cycles. Required: `out_data` = 0x11, 0x22, 0x33 one cycle later each; `level` stays 1; `stall_cnt=0`.
2. **Back-pressure, mode 1.** `out_ready=0`; offer 0xA, 0xB, 0xC. Required: 0xA and 0xB accepted; `in_ready=0` and `level=2` after the 2nd edge; 0xC held off; `stall_cnt` counts each stalled cycle. Then raise `out_ready`: delivered order is 0xA, 0xB, 0xC.
3. **Mode 0 pass-through ready.** Full, `out_ready=1`, `in_valid=1`: accepted the same cycle, `level` stays 1. With `out_ready=0`: `in_ready=0`.
4. **Flush while FULL2.**
   - Assert `flush` with `in_valid=1` and `out_ready=0`. Required: next cycle `level=0` and `out_valid=0`; the flush-cycle beat never appears; `stall_cnt` is unchanged by the flush.
   - Then offer 0x5. Required: 0x5 is delivered normally.
5. **Saturation.** `CNT_W=3`, hold a stall for 10 cycles. Required: `stall_cnt` reads 7 and stays 7.
6. **Reset mid-operation.** Assert `reset` while `level=2`. Required: next cycle all outputs are at their reset values; simultaneous `reset` and `flush` gives the same result.

Source files
------------

// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register between two adjacent pipeline stages.
// SKID=0 gives a single register with combinational ready; SKID=1 gives a two-entry skid buffer with registered ready.
module pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_v_reg, main_v_next;
  logic             skid_v_reg, skid_v_next;
  logic [WIDTH-1:0] main_d_reg, main_d_next;
  logic [WIDTH-1:0] skid_d_reg, skid_d_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             accept;
  logic             deliver;
  logic             stalled;

  assign accept  = in_valid && in_ready;
  assign deliver = main_v_reg && out_ready;
  assign stalled = main_v_reg && !out_ready;

  always_comb begin
    main_v_next = main_v_reg;
    main_d_next = main_d_reg;
    skid_v_next = skid_v_reg;
    skid_d_next = skid_d_reg;
    if (SKID == 0) begin
      if (accept) begin
        main_v_next = 1'b1;
        main_d_next = in_data;
      end else if (deliver) begin
        main_v_next = 1'b0;
      end
    end else begin
      if (!main_v_reg) begin
        if (accept) begin
          main_v_next = 1'b1;
          main_d_next = in_data;
        end
      end else if (!skid_v_reg) begin
        if (deliver && accept) begin
          main_d_next = in_data;
        end else if (deliver) begin
          main_v_next = 1'b0;
        end else if (accept) begin
          skid_v_next = 1'b1;
          skid_d_next = in_data;
        end
      end else if (deliver) begin
        // Skid entry moves up behind the departing beat, preserving order.
        main_d_next = skid_d_reg;
        skid_v_next = 1'b0;
      end
    end
    // Squash only drops the valid bits; payload registers are don't-care afterwards.
    if (flush) begin
      main_v_next = 1'b0;
      skid_v_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_reg    <= 1'b0;
      main_d_reg    <= '0;
      skid_v_reg    <= 1'b0;
      skid_d_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      main_v_reg <= main_v_next;
      main_d_reg <= main_d_next;
      skid_v_reg <= skid_v_next;
      skid_d_reg <= skid_d_next;
      if (stalled && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // Ready is the registered complement of the next skid state, so out_ready never reaches in_ready combinationally.
      logic ready_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          ready_reg <= 1'b1;
        end else begin
          ready_reg <= !skid_v_next;
        end
      end
      assign in_ready = ready_reg;
    end else begin : g_single
      assign in_ready = !main_v_reg || out_ready;
    end
  endgenerate

  assign out_valid = main_v_reg;
  assign out_data  = main_d_reg;
  assign level     = {1'b0, main_v_reg} + {1'b0, skid_v_reg};
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: three instances (single register, skid buffer, skid buffer with 3-bit counter) on shared stimulus,
// checked against directed vectors and a queue-style occupancy model.
module tb_pipe_stage;

  logic        clk;
  logic        rst;
  logic        fl;
  logic        iv;
  logic [7:0]  id;
  logic        ordy;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [7:0]  od [3];
  logic [1:0]  lv [3];
  logic [15:0] sc0;
  logic [15:0] sc1;
  logic [2:0]  sc3;

  int checks = 0;
  int errors = 0;

  // Model: each instance is a FIFO of capacity 1 (mode 0) or 2 (mode 1).
  int         mmode [3] = '{0, 1, 1};
  int         smax  [3] = '{65535, 65535, 7};
  int         mlev  [3];
  int         mst   [3];
  logic [7:0] mbuf  [3][2];
  logic       mrdy  [3];

  typedef struct {
    logic       rst, fl, iv;
    logic [7:0] id;
    logic       ordy;
    logic       ev, cd;
    logic [7:0] ed;
    logic [1:0] el;
    logic       er;
    logic [15:0] es;
  } vec_t;

  vec_t vt [27];

  pipe_stage #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(ir[0]), .in_data(id),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]), .level(lv[0]), .stall_cnt(sc0));

  pipe_stage #(.WIDTH(8), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(ir[1]), .in_data(id),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]), .level(lv[1]), .stall_cnt(sc1));

  pipe_stage #(.WIDTH(8), .SKID(1), .CNT_W(3)) dut3 (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(ir[2]), .in_data(id),
    .out_valid(ov[2]), .out_ready(ordy), .out_data(od[2]), .level(lv[2]), .stall_cnt(sc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, f, v, d, o, ev, cd, ed, el, er, es);
    vec_t m;
    m.rst = r[0]; m.fl = f[0]; m.iv = v[0]; m.id = d[7:0]; m.ordy = o[0];
    m.ev = ev[0]; m.cd = cd[0]; m.ed = ed[7:0]; m.el = el[1:0]; m.er = er[0]; m.es = es[15:0];
    return m;
  endfunction

  function automatic logic [31:0] get_sc(input int k);
    if (k == 0) return {16'h0, sc0};
    if (k == 1) return {16'h0, sc1};
    return {29'h0, sc3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, let them settle, and compare every instance with the model.
  task automatic apply(input int r, f, v, d, o);
    rst = r[0]; fl = f[0]; iv = v[0]; id = d[7:0]; ordy = o[0];
    #1;
    for (int k = 0; k < 3; k++) begin
      mrdy[k] = (mmode[k] != 0) ? (mlev[k] < 2) : ((mlev[k] == 0) || ordy);
      chk($sformatf("in_ready[%0d]", k), 32'(ir[k]), 32'(mrdy[k]));
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(mlev[k] > 0));
      chk($sformatf("level[%0d]", k), 32'(lv[k]), 32'(mlev[k]));
      chk($sformatf("stall_cnt[%0d]", k), get_sc(k), 32'(mst[k]));
      if (mlev[k] > 0) chk($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(mbuf[k][0]));
    end
  endtask

  // Update the model for the coming edge, then move past it.
  task automatic advance();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mlev[k] = 0;
        mst[k]  = 0;
      end else begin
        if (mlev[k] > 0 && !ordy && mst[k] < smax[k]) mst[k]++;
        if (mlev[k] > 0 && ordy) begin
          mbuf[k][0] = mbuf[k][1];
          mlev[k]--;
        end
        if (iv && mrdy[k]) begin
          mbuf[k][mlev[k]] = id;
          mlev[k]++;
        end
        if (fl) mlev[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst fl iv  id   ordy | ev cd ed    el er es
    vt[0]  = mk(0, 0, 1, 'h11, 1,  0, 0, 'h00, 0, 1, 0);
    vt[1]  = mk(0, 0, 1, 'h22, 1,  1, 1, 'h11, 1, 1, 0);
    vt[2]  = mk(0, 0, 1, 'h33, 1,  1, 1, 'h22, 1, 1, 0);
    vt[3]  = mk(0, 0, 0, 'h00, 1,  1, 1, 'h33, 1, 1, 0);
    vt[4]  = mk(0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 1, 0);
    vt[5]  = mk(0, 0, 1, 'h0A, 0,  0, 0, 'h00, 0, 1, 0);
    vt[6]  = mk(0, 0, 1, 'h0B, 0,  1, 1, 'h0A, 1, 1, 0);
    vt[7]  = mk(0, 0, 1, 'h0C, 0,  1, 1, 'h0A, 2, 0, 1);
    vt[8]  = mk(0, 0, 1, 'h0C, 1,  1, 1, 'h0A, 2, 0, 2);
    vt[9]  = mk(0, 0, 1, 'h0C, 1,  1, 1, 'h0B, 1, 1, 2);
    vt[10] = mk(0, 0, 0, 'h00, 1,  1, 1, 'h0C, 1, 1, 2);
    vt[11] = mk(0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 1, 2);
    vt[12] = mk(0, 0, 1, 'h44, 0,  0, 0, 'h00, 0, 1, 2);
    vt[13] = mk(0, 0, 1, 'h55, 0,  1, 1, 'h44, 1, 1, 2);
    vt[14] = mk(0, 1, 1, 'h66, 0,  1, 1, 'h44, 2, 0, 3);
    vt[15] = mk(0, 1, 1, 'h77, 0,  0, 0, 'h00, 0, 1, 4);
    vt[16] = mk(0, 0, 1, 'h05, 1,  0, 0, 'h00, 0, 1, 4);
    vt[17] = mk(0, 0, 0, 'h00, 1,  1, 1, 'h05, 1, 1, 4);
    vt[18] = mk(0, 0, 0, 'h00, 1,  0, 0, 'h00, 0, 1, 4);
    vt[19] = mk(0, 0, 1, 'h81, 0,  0, 0, 'h00, 0, 1, 4);
    vt[20] = mk(0, 0, 1, 'h82, 0,  1, 1, 'h81, 1, 1, 4);
    vt[21] = mk(1, 0, 0, 'h00, 0,  1, 1, 'h81, 2, 0, 5);
    vt[22] = mk(0, 0, 0, 'h00, 0,  0, 1, 'h00, 0, 1, 0);
    vt[23] = mk(0, 0, 1, 'h91, 0,  0, 0, 'h00, 0, 1, 0);
    vt[24] = mk(0, 0, 1, 'h92, 0,  1, 1, 'h91, 1, 1, 0);
    vt[25] = mk(1, 1, 1, 'h93, 0,  1, 1, 'h91, 2, 0, 1);
    vt[26] = mk(0, 0, 0, 'h00, 0,  0, 1, 'h00, 0, 1, 0);

    for (int k = 0; k < 3; k++) begin
      mlev[k] = 0;
      mst[k]  = 0;
      mbuf[k][0] = 8'h00;
      mbuf[k][1] = 8'h00;
    end
    rst = 1'b1; fl = 1'b0; iv = 1'b0; id = 8'h00; ordy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed vectors, expectations written for the skid-buffer instance.
    for (int i = 0; i < 27; i++) begin
      apply(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
      $display("vec %0d: rst=%0b flush=%0b in_valid=%0b in_data=%02h out_ready=%0b -> out_valid=%0b out_data=%02h level=%0d in_ready=%0b stall=%0d",
               i, rst, fl, iv, id, ordy, ov[1], od[1], lv[1], ir[1], sc1);
      chk($sformatf("vec%0d out_valid", i), 32'(ov[1]), 32'(vt[i].ev));
      chk($sformatf("vec%0d level", i), 32'(lv[1]), 32'(vt[i].el));
      chk($sformatf("vec%0d in_ready", i), 32'(ir[1]), 32'(vt[i].er));
      chk($sformatf("vec%0d stall_cnt", i), 32'(sc1), 32'(vt[i].es));
      if (vt[i].cd) chk($sformatf("vec%0d out_data", i), 32'(od[1]), 32'(vt[i].ed));
      advance();
    end

    // Single-register mode: a full stage passes a new beat through when downstream is ready.
    apply(1, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 'hA1, 0); advance();
    apply(0, 0, 1, 'hA2, 1);
    chk("m0_ready_pass", 32'(ir[0]), 32'd1);
    chk("m0_level_full", 32'(lv[0]), 32'd1);
    advance();
    apply(0, 0, 1, 'hA3, 0);
    chk("m0_data_refill", 32'(od[0]), 32'h0A2);
    chk("m0_level_kept", 32'(lv[0]), 32'd1);
    chk("m0_ready_block", 32'(ir[0]), 32'd0);
    advance();

    // Counter saturation over a 10-cycle stall.
    apply(1, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 'h5A, 0); advance();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 0); advance();
    end
    apply(0, 0, 0, 0, 0);
    chk("sat_cnt3", {29'h0, sc3}, 32'd7);
    chk("sat_cnt16", 32'(sc1), 32'd10);
    advance();
    apply(0, 0, 0, 0, 0);
    chk("sat_hold", {29'h0, sc3}, 32'd7);
    advance();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 99) < 2) ? 1 : 0,
            ($urandom_range(0, 99) < 5) ? 1 : 0,
            ($urandom_range(0, 99) < 60) ? 1 : 0,
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 99) < 60) ? 1 : 0);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
